rename_free_list: RTL

- Circular free list of physical register (PRF) ids for the 2-wide rename stage.
- Supplies up to two fresh destination PRF ids per cycle to rename; these feed the rename fl_prf_id field.
- Reclaims up to two ids per cycle from the ROB: T_old on retire, or T during rob_walk rollback.
- Sits between ROB retire/walk (upstream of its release side) and rename (downstream of its allocate side).

---
 rtl/rename_free_list.sv | 114 +++++++++++
 1 files changed

// File: rtl/rename_free_list.sv
// Circular free list of physical register ids for a 2-wide rename stage.
// Define FL_CHECK_EN to add an in-list bitmap that flags duplicate releases on dup_err.
module rename_free_list #(
  parameter int unsigned PRF_NUM   = 64,
  parameter int unsigned FL_NUM    = 32,
  parameter int unsigned FL_WIDTH  = 5,
  parameter int unsigned PRF_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_req_0,
  input  logic                 alloc_req_1,
  output logic                 alloc_ready,
  output logic [PRF_WIDTH-1:0] alloc_prf_0,
  output logic [PRF_WIDTH-1:0] alloc_prf_1,
  input  logic                 rel_valid_0,
  input  logic [PRF_WIDTH-1:0] rel_prf_0,
  input  logic                 rel_valid_1,
  input  logic [PRF_WIDTH-1:0] rel_prf_1,
  output logic [FL_WIDTH:0]    free_count,
  output logic                 fl_empty,
  output logic                 dup_err
);

  localparam int unsigned CW = FL_WIDTH + 1;

  logic [PRF_WIDTH-1:0] entry_q [FL_NUM];
  logic [FL_WIDTH-1:0]  head_q, head_d, head_p1;
  logic [FL_WIDTH-1:0]  tail_q, tail_d, tail_w1;
  logic [CW-1:0]        count_q, count_d;
  logic [1:0]           n_req, n_pop, n_push;
  logic                 push_0, push_1, fire;

  assign n_req   = {1'b0, alloc_req_0} + {1'b0, alloc_req_1};
  assign alloc_ready = count_q >= CW'(n_req);
  assign fire    = alloc_ready && (alloc_req_0 || alloc_req_1);
  assign n_pop   = fire ? n_req : 2'd0;

  // x0 is never freed, so a zero id on a release slot is dropped.
  assign push_0  = rel_valid_0 && (rel_prf_0 != '0);
  assign push_1  = rel_valid_1 && (rel_prf_1 != '0);
  assign n_push  = {1'b0, push_0} + {1'b0, push_1};

  assign head_p1 = head_q + FL_WIDTH'(1);
  assign tail_w1 = push_0 ? tail_q + FL_WIDTH'(1) : tail_q;

  assign head_d  = head_q + FL_WIDTH'(n_pop);
  assign tail_d  = tail_q + FL_WIDTH'(n_push);
  assign count_d = count_q - CW'(n_pop) + CW'(n_push);

  // A lone request on slot 1 takes the head entry; otherwise slot 1 looks one ahead.
  assign alloc_prf_0 = entry_q[head_q];
  assign alloc_prf_1 = (alloc_req_1 && !alloc_req_0) ? entry_q[head_q] : entry_q[head_p1];

  assign free_count = count_q;
  assign fl_empty   = (count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FL_NUM); i++) begin
        entry_q[i] <= PRF_WIDTH'(PRF_NUM - FL_NUM + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(FL_NUM);
    end else begin
      if (push_0) entry_q[tail_q]  <= rel_prf_0;
      if (push_1) entry_q[tail_w1] <= rel_prf_1;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef FL_CHECK_EN
  logic [PRF_NUM-1:0] in_list_q, in_list_d;
  logic               dup_err_q, dup_err_d;

  // Clears from this cycle's grant are applied before the release checks.
  always_comb begin
    in_list_d = in_list_q;
    dup_err_d = dup_err_q;
    if (fire && alloc_req_0) in_list_d[alloc_prf_0] = 1'b0;
    if (fire && alloc_req_1) in_list_d[alloc_prf_1] = 1'b0;
    if (push_0) begin
      if (in_list_d[rel_prf_0]) dup_err_d = 1'b1;
      in_list_d[rel_prf_0] = 1'b1;
    end
    if (push_1) begin
      if (in_list_d[rel_prf_1]) dup_err_d = 1'b1;
      in_list_d[rel_prf_1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_list_q <= {{FL_NUM{1'b1}}, {(PRF_NUM - FL_NUM){1'b0}}};
      dup_err_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      dup_err_q <= dup_err_d;
    end
  end

  assign dup_err = dup_err_q;
`else
  assign dup_err = 1'b0;
`endif

  overflow_chk: assert property (@(posedge clk) disable iff (reset)
    (count_q + CW'(n_push)) <= CW'(FL_NUM))
    else $error("free list overflow: count %0d push %0d", count_q, n_push);

endmodule
